picosoc_native_wb_bridge: RTL and testbench
===========================================

Name: picosoc_native_wb_bridge

Overview:
- Upstream master stage for the SoC Wishbone bus.
- Converts the picorv32 native memory handshake (mem_valid/mem_ready) into single Wishbone classic-cycle transactions.
- Feeds the on-chip RAM slave and the other Wishbone peripherals.
- A cycle timeout and error capture stop an unresponsive slave from hanging the CPU.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles spent in BUS without ack/err before the bridge forces termination (1..65535, 16-bit counter)
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the CPU on error or timeout

Ports:
wb_clk_i  in  1  single system clock; all logic on rising edge
wb_rst_i  in  1  synchronous, active-high reset
mem_valid  in  1  CPU request valid
mem_instr  in  1  CPU instruction-fetch flag (informational, latched into err_instr_o)
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  CPU byte strobes; 0 = read
mem_ready  out  1  one-cycle completion pulse to CPU
mem_rdata  out  32  read data to CPU
wbm_adr_o  out  32  Wishbone address (byte address, passed through unmodified)
wbm_dat_o  out  32  Wishbone write data
wbm_dat_i  in  32  Wishbone read data
wbm_sel_o  out  4  byte selects
wbm_we_o  out  1  write enable
wbm_cyc_o  out  1  cycle
wbm_stb_o  out  1  strobe
wbm_ack_i  in  1  slave acknowledge
wbm_err_i  in  1  slave error
err_clr_i  in  1  clears sticky error status
bus_err_o  out  1  sticky: an error or timeout has occurred
err_addr_o  out  32  address of the most recent failed transaction
err_instr_o  out  1  mem_instr value of the most recent failed transaction

Behaviour:
- Reset values (registered, applied on wb_rst_i at a clock edge):
  - Outputs cleared: mem_ready, mem_rdata, all wbm_* outputs, bus_err_o, err_addr_o, err_instr_o = 0.
  - State = IDLE, timeout counter = 0.
- All outputs are registered. There is no combinational path from mem_* or wbm_* inputs to outputs.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - Trigger: mem_valid=1 and mem_ready=0.
  - Latch mem_addr into wbm_adr_o and mem_wdata into wbm_dat_o.
  - Set wbm_we_o = |mem_wstrb.
  - Set wbm_sel_o = mem_wstrb for writes, 4'hF for reads.
  - Set wbm_cyc_o = wbm_stb_o = 1, clear the counter, go to BUS.
- BUS, checked each edge in this priority order:
  1. wbm_err_i=1 (wins over a simultaneous ack):
     - Drop cyc/stb; mem_rdata = ERR_RDATA for reads.
     - Set bus_err_o; latch err_addr_o and err_instr_o.
     - Pulse mem_ready; go to DONE.
  2. wbm_ack_i=1:
     - Drop cyc/stb; for reads, capture wbm_dat_i into mem_rdata (writes leave mem_rdata unchanged).
     - Pulse mem_ready; go to DONE.
  3. Counter == TIMEOUT_CYCLES-1 (ack/err on the same edge take precedence):
     - Handled the same as err.
  4. Otherwise, increment the counter.
- DONE:
  - mem_ready returns to 0; go to IDLE.
  - Any wbm_ack_i/wbm_err_i seen here is ignored. This absorbs the stale ack from slaves whose registered ack = stb&&cyc persists one cycle after cyc drops.
- Minimum latency with a registered-ack slave:
  - mem_valid sampled at edge N.
  - cyc/stb high after N.
  - Ack seen at N+2; mem_ready high for the cycle after N+2.
  - Next request accepted at edge N+4 at the earliest.
- wbm_* signals hold stable throughout BUS. mem_* inputs are not re-sampled until IDLE.
- mem_valid dropping mid-transaction is a CPU protocol violation. The bridge completes the cycle regardless.
- err_clr_i=1:
  - Clears bus_err_o at the next edge.
  - If a new error occurs on the same edge, the error wins (bus_err_o stays 1, err_addr_o updates).
  - err_addr_o and err_instr_o are not cleared by err_clr_i.
- Reset mid-transaction: cyc/stb and mem_ready are 0 after the reset edge, FSM returns to IDLE, and the in-flight request is abandoned.
- Width rules:
  - Counter is 16 bits and never wraps: termination occurs at TIMEOUT_CYCLES-1.
  - Addresses are passed as full 32-bit byte addresses; slaves do their own word slicing.

Test Plan:
- Read, slave with registered ack (ack=stb&&cyc delayed one cycle), mem_addr=0x0000_0010, slave data 0x1234_5678 -> cyc/stb high for 2 cycles, wbm_sel_o=4'hF, wbm_we_o=0, mem_ready single pulse 3 cycles after request, mem_rdata=0x1234_5678, stale ack in DONE ignored.
- Byte write, mem_wstrb=4'b0100, mem_wdata=0xAABB_CCDD, addr 0x20 -> wbm_we_o=1, wbm_sel_o=4'b0100, wbm_dat_o=0xAABB_CCDD, exactly one mem_ready pulse, mem_rdata unchanged.
- Back-to-back requests (mem_valid held high with new address right after mem_ready) -> two distinct Wishbone cycles separated by at least 1 idle cycle; no duplicate cycle issued from the stale ack.
- Slave never acks, TIMEOUT_CYCLES=8, read at 0x0300_0000 -> cyc drops after 8 BUS cycles, mem_rdata=0xDEAD_BEEF, bus_err_o=1, err_addr_o=0x0300_0000; err_clr_i pulse -> bus_err_o=0.
- ack and err asserted on the same edge -> error path taken (bus_err_o=1, mem_rdata=ERR_RDATA); err_clr_i together with a new err -> bus_err_o stays 1.
- wb_rst_i asserted while in BUS -> next edge: cyc/stb/mem_ready=0, FSM in IDLE; the next request after reset completes normally.

Source files
------------

// File: rtl/picosoc_native_wb_bridge_if.sv
// Bundles the picorv32 native memory handshake and the Wishbone classic master bus
// seen by the native-to-Wishbone bridge.
//   master: the bridge's own view (answers the CPU, drives Wishbone).
//   slave:  the surrounding system's view (CPU side plus the Wishbone slave).
interface picosoc_native_wb_bridge_if;
    // CPU native memory interface
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Wishbone classic master bus
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/picosoc_native_wb_bridge.sv
// picorv32 native memory handshake to single Wishbone classic cycles.
// Every output is registered. A 16-bit cycle counter bounds how long a cycle may
// stay open; an error or timeout completes the CPU access with ERR_RDATA and is
// recorded in sticky status registers.
module picosoc_native_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    picosoc_native_wb_bridge_if.master        bus,
    input  logic                              err_clr_i,
    output logic                              bus_err_o,
    output logic [31:0]                       err_addr_o,
    output logic                              err_instr_o
);

    // Counter value at which an open cycle is forcibly terminated.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;      // drives both cyc and stb
    logic        instr_q, instr_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_instr_q, err_instr_d;
    logic        fail;

    // Next-state and output computation for the IDLE/BUS/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        instr_d     = instr_q;
        bus_err_d   = bus_err_q;
        err_addr_d  = err_addr_q;
        err_instr_d = err_instr_q;
        fail        = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.mem_valid && !ready_q) begin
                    adr_d   = bus.mem_addr;
                    dat_d   = bus.mem_wdata;
                    we_d    = |bus.mem_wstrb;
                    sel_d   = (|bus.mem_wstrb) ? bus.mem_wstrb : 4'hF;
                    instr_d = bus.mem_instr;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                // err beats ack, and both beat the timeout on the same edge.
                if (bus.wbm_err_i) begin
                    fail = 1'b1;
                end else if (bus.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = bus.wbm_dat_i;
                    end
                    state_d = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                // Stale ack/err from a registered-ack slave lands here and is dropped.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (err_clr_i) begin
            bus_err_d = 1'b0;
        end

        // A fresh failure overrides a simultaneous clear.
        if (fail) begin
            cyc_d       = 1'b0;
            ready_d     = 1'b1;
            bus_err_d   = 1'b1;
            err_addr_d  = adr_q;
            err_instr_d = instr_q;
            if (!we_q) begin
                rdata_d = ERR_RDATA;
            end
            state_d = StDone;
        end
    end

    // State and registered outputs, synchronously reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            instr_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_instr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            instr_q     <= instr_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
            err_instr_q <= err_instr_d;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus_err_o     = bus_err_q;
    assign err_addr_o    = err_addr_q;
    assign err_instr_o   = err_instr_q;

endmodule

// File: tb/tb_picosoc_native_wb_bridge.sv
// Bench for picosoc_native_wb_bridge: directed cases plus randomized transactions
// against a transaction-level reference model and a behavioural Wishbone slave.
module tb_picosoc_native_wb_bridge;

    localparam int unsigned Timeout = 8;
    localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

    // Slave behaviour selectors
    localparam int ModeAck  = 0;
    localparam int ModeErr  = 1;
    localparam int ModeBoth = 2;
    localparam int ModeNone = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        bus_err;
    logic [31:0] err_addr;
    logic        err_instr;

    picosoc_native_wb_bridge_if bus ();

    picosoc_native_wb_bridge #(
        .TIMEOUT_CYCLES (Timeout),
        .ERR_RDATA      (ErrData)
    ) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .bus         (bus),
        .err_clr_i   (err_clr),
        .bus_err_o   (bus_err),
        .err_addr_o  (err_addr),
        .err_instr_o (err_instr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural slave: registered ack/err after slv_lat extra cycles; the
    // response lingers one cycle after cyc drops, like ack <= stb && cyc.
    int          slv_mode = ModeAck;
    int          slv_lat  = 0;
    int          slv_cnt  = 0;
    logic [31:0] slv_data = '0;

    assign bus.wbm_dat_i = slv_data;

    always @(posedge clk) begin
        if (rst || !(bus.wbm_cyc_o && bus.wbm_stb_o)) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_err_i <= 1'b0;
            slv_cnt       <= 0;
        end else begin
            slv_cnt <= slv_cnt + 1;
            if (slv_cnt >= slv_lat && slv_mode != ModeNone) begin
                bus.wbm_ack_i <= (slv_mode == ModeAck) || (slv_mode == ModeBoth);
                bus.wbm_err_i <= (slv_mode == ModeErr) || (slv_mode == ModeBoth);
            end else begin
                bus.wbm_ack_i <= 1'b0;
                bus.wbm_err_i <= 1'b0;
            end
        end
    end

    // Counts Wishbone cycles actually opened, to catch duplicates.
    logic cyc_prev   = 1'b0;
    int   cyc_starts = 0;
    always @(posedge clk) begin
        cyc_prev <= bus.wbm_cyc_o;
        if (bus.wbm_cyc_o === 1'b1 && cyc_prev !== 1'b1) begin
            cyc_starts <= cyc_starts + 1;
        end
    end

    // Reference model: architectural results of completed CPU accesses.
    logic [31:0] m_rdata;
    logic        m_bus_err;
    logic [31:0] m_err_addr;
    logic        m_err_instr;
    int          m_txns;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rdata     = '0;
        m_bus_err   = 1'b0;
        m_err_addr  = '0;
        m_err_instr = 1'b0;
    endtask

    // Issue one CPU access starting at a negedge; returns at the negedge where
    // mem_ready is expected high. exp_start is 1 from IDLE, 2 when issued
    // back-to-back right after a completion.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr, input int mode,
                           input int lat, input logic [31:0] sdata, input int exp_start,
                           input bit clr);
        int          k;
        int          hi;
        int          early;
        int          bad;
        int          exp_hi;
        bit          is_rd;
        bit          is_err;
        logic [3:0]  exp_sel;
        is_rd   = (wstrb == 4'h0);
        is_err  = (mode != ModeAck);
        exp_sel = is_rd ? 4'hF : wstrb;
        exp_hi  = (mode == ModeNone) ? int'(Timeout) : lat + 2;

        slv_mode      = mode;
        slv_lat       = lat;
        slv_data      = sdata;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        bus.mem_instr = instr;
        err_clr       = clr;

        k     = 0;
        early = 0;
        do begin
            @(negedge clk);
            k++;
            if (bus.mem_ready !== 1'b0) early++;
        end while (bus.wbm_cyc_o !== 1'b1 && k < 20);
        check_eq("start_latency", 32'(k), 32'(exp_start));
        check_eq("no_early_ready", 32'(early), 32'd0);
        check_eq("wb_adr", bus.wbm_adr_o, addr);
        check_eq("wb_sel", 32'(bus.wbm_sel_o), 32'(exp_sel));
        check_eq("wb_we", 32'(bus.wbm_we_o), 32'(!is_rd));
        if (!is_rd) check_eq("wb_dat", bus.wbm_dat_o, wdata);

        // Wishbone signals must hold while the cycle is open.
        hi  = 0;
        bad = 0;
        while (bus.wbm_cyc_o === 1'b1 && hi < 100) begin
            hi++;
            if (bus.wbm_stb_o !== 1'b1 || bus.wbm_adr_o !== addr ||
                bus.wbm_sel_o !== exp_sel || bus.mem_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        check_eq("cyc_length", 32'(hi), 32'(exp_hi));
        check_eq("wb_stable", 32'(bad), 32'd0);
        check_eq("stb_dropped", 32'(bus.wbm_stb_o), 32'd0);

        if (is_err) begin
            if (is_rd) m_rdata = ErrData;
            m_bus_err   = 1'b1;
            m_err_addr  = addr;
            m_err_instr = instr;
        end else begin
            if (is_rd) m_rdata = sdata;
            if (clr) m_bus_err = 1'b0;
        end
        m_txns++;

        check_eq("mem_ready", 32'(bus.mem_ready), 32'd1);
        check_eq("mem_rdata", bus.mem_rdata, m_rdata);
        check_eq("bus_err", 32'(bus_err), 32'(m_bus_err));
        check_eq("err_addr", err_addr, m_err_addr);
        check_eq("err_instr", 32'(err_instr), 32'(m_err_instr));
        err_clr = 1'b0;
    endtask

    // Drop the request and expect a quiet bus for n cycles.
    task automatic idle(input int n);
        int bad;
        bad           = 0;
        bus.mem_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.wbm_cyc_o !== 1'b0 || bus.mem_ready !== 1'b0) bad++;
        end
        check_eq("idle_quiet", 32'(bad), 32'd0);
    endtask

    task automatic clear_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        m_bus_err = 1'b0;
        check_eq("err_clear", 32'(bus_err), 32'(m_bus_err));
        check_eq("err_addr_kept", err_addr, m_err_addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          b2b;
        int          r;
        int          mode;
        logic [3:0]  strb;

        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        m_txns        = 0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_ready", 32'(bus.mem_ready), 32'd0);
        check_eq("rst_rdata", bus.mem_rdata, 32'd0);
        check_eq("rst_adr", bus.wbm_adr_o, 32'd0);
        check_eq("rst_dat", bus.wbm_dat_o, 32'd0);
        check_eq("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
        check_eq("rst_we", 32'(bus.wbm_we_o), 32'd0);
        check_eq("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check_eq("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        check_eq("rst_err_addr", err_addr, 32'd0);
        check_eq("rst_err_instr", 32'(err_instr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Registered-ack read, then a byte write that must keep mem_rdata.
        run_txn(32'h0000_0010, 32'h0, 4'h0, 1'b1, ModeAck, 0, 32'h1234_5678, 1, 1'b0);
        idle(2);
        run_txn(32'h0000_0020, 32'hAABB_CCDD, 4'b0100, 1'b0, ModeAck, 0, 32'h5555_AAAA, 1,
                1'b0);
        idle(2);

        // Back-to-back: the stale ack must not open a duplicate cycle.
        run_txn(32'h0000_0030, 32'h0, 4'h0, 1'b0, ModeAck, 1, 32'h0BAD_F00D, 1, 1'b0);
        run_txn(32'h0000_0034, 32'h0, 4'h0, 1'b0, ModeAck, 0, 32'hC0FF_EE00, 2, 1'b0);
        idle(2);
        check_eq("cycle_count_b2b", 32'(cyc_starts), 32'(m_txns));

        // Silent slave: timeout, then sticky error clear.
        run_txn(32'h0300_0000, 32'h0, 4'h0, 1'b1, ModeNone, 0, 32'h1111_1111, 1, 1'b0);
        idle(2);
        clear_pulse();

        // ack+err on one edge takes the error path; clear racing a new error loses.
        run_txn(32'h0000_0040, 32'h0, 4'h0, 1'b0, ModeBoth, 0, 32'h2222_2222, 1, 1'b0);
        idle(1);
        run_txn(32'h0000_0044, 32'h0, 4'h0, 1'b1, ModeErr, 2, 32'h3333_3333, 1, 1'b1);
        idle(1);

        // Reset while the cycle is open.
        slv_mode      = ModeNone;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0050;
        bus.mem_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        rst           = 1'b1;
        bus.mem_valid = 1'b0;
        m_txns++;
        @(negedge clk);
        model_reset();
        check_eq("midrst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check_eq("midrst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check_eq("midrst_ready", 32'(bus.mem_ready), 32'd0);
        check_eq("midrst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_txn(32'h0000_0060, 32'h0, 4'h0, 1'b0, ModeAck, 0, 32'h7777_8888, 1, 1'b0);
        idle(1);

        // Randomized traffic.
        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            mode = (r == 6) ? ModeErr : (r == 7) ? ModeBoth : (r == 8) ? ModeNone : ModeAck;
            strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn($urandom, $urandom, strb, 1'($urandom_range(0, 1)), mode,
                    $urandom_range(0, 3), $urandom, b2b ? 2 : 1, $urandom_range(0, 4) == 0);
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) idle($urandom_range(1, 3));
        end
        idle(3);
        check_eq("cycle_count_total", 32'(cyc_starts), 32'(m_txns));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
